syn_fifo: RTL and testbench
===========================

Name: syn_fifo

Overview:
- Single-clock synchronous FIFO that buffers WIDTH-bit words between a producer (write side) and a consumer (read side) in the same clock domain.
- Provides full and empty status flags so both sides can throttle themselves.
- Requests made against a full or empty FIFO are ignored.
- Intended as a generic buffer between datapath stages, for example ahead of the SHA3 absorb logic.

Parameters:
- WIDTH, 8: bit width of each data word.
- DEPTH, 4: number of storage entries; must be a power of two and at least 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- w_data  input  WIDTH  write data, sampled on the rising edge of clk when a write is accepted.
- w_request  input  1  write request; level-sensitive, one write per clock while high.
- r_request  input  1  read request; level-sensitive, one read per clock while high.
- r_data  output  WIDTH  registered read data.
- full_status  output  1  high when DEPTH entries are stored.
- empty_status  output  1  high when 0 entries are stored.

Behaviour:
- Reset (rst_n low, asynchronous, overrides everything):
  - write pointer, read pointer and count go to 0.
  - r_data goes to 0, empty_status to 1, full_status to 0.
  - Storage array contents are don't-care.
  - Reset asserted mid-operation discards all stored data immediately.
- Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0. Occupancy is tracked by a count register 0..DEPTH, or equivalently by an extra pointer MSB.
- Write accept: wr_en = w_request & ~full_status.
  - On the clock edge: mem[wptr] <= w_data; wptr increments.
  - A write while full is dropped silently; no state changes.
- Read accept: rd_en = r_request & ~empty_status.
  - On the clock edge: r_data <= mem[rptr]; rptr increments.
  - Read latency is 1 clock: data appears on r_data after the edge that accepts the read.
  - r_data holds its last value when no read is accepted, including a read while empty.
- Count update on each edge:
  - +1 if wr_en only.
  - -1 if rd_en only.
  - unchanged if both or neither.
- Simultaneous read and write:
  - Both accepted when 0 < count < DEPTH; order is preserved.
  - When empty, only the write is accepted (no bypass/fall-through); count becomes 1 and r_data is unchanged.
  - When full, only the read is accepted; count becomes DEPTH-1 and full_status deasserts.
- Flags are registered/derived from count:
  - full_status = (count == DEPTH); empty_status = (count == 0).
  - Both are valid in the same cycle the count changes, with no extra lag.
  - The two flags are never high together.
- Data ordering is strict first-in first-out across any number of pointer wrap-arounds.
- No X propagation on r_data after reset, even when reading uninitialised entries is impossible by construction.

Test Plan:
- Reset: drive rst_n low asynchronously mid-cycle -> immediately empty_status=1, full_status=0, r_data=0x00; a subsequent read is ignored and r_data stays 0x00.
- Fill: write 0x00,0x01,0x02,0x03 on consecutive clocks with r_request=0 -> full_status=1 after the 4th edge; a write of 0x04 on the next clock is dropped and full_status stays 1.
- Drain: from that full state, hold r_request=1 for 5 clocks -> r_data is 0x00,0x01,0x02,0x03 after successive edges; empty_status=1 after the 4th edge; the 5th read is ignored and r_data holds 0x03.
- Concurrent: with 2 entries (0x10,0x11) stored, assert w_request and r_request together for 3 clocks writing 0x12,0x13,0x14 -> r_data is 0x10,0x11,0x12; count stays 2; neither flag asserts.
- Boundary simultaneity:
  - Full plus both requests -> read accepted, write dropped, full_status=0.
  - Empty plus both requests writing 0x55 -> write only, r_data unchanged, empty_status=0; the next read returns 0x55.
- Wrap and mid-operation reset: stream 0x00..0x0C continuously with intermittent reads -> output sequence strictly increasing with no duplicates, beyond 3 pointer wraps. Then pulse rst_n low with 2 entries stored -> empty_status=1 at once, and the stale entries are never read.

Source files
------------

// File: rtl/syn_fifo.sv
// Single-clock FIFO with registered read data and count-derived full/empty flags.
// Requests against a full or empty FIFO are dropped; there is no write-to-read bypass.
module syn_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] w_data,
   input  logic             w_request,
   input  logic             r_request,
   output logic [WIDTH-1:0] r_data,
   output logic             full_status,
   output logic             empty_status
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic [AW:0]      count;
   logic             wr_en;
   logic             rd_en;

   assign full_status  = (count == FULL_CNT);
   assign empty_status = (count == '0);
   assign wr_en        = w_request & ~full_status;
   assign rd_en        = r_request & ~empty_status;

   // Storage needs no reset; a read can only reach entries that were written.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wptr] <= w_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr   <= '0;
         rptr   <= '0;
         count  <= '0;
         r_data <= '0;
      end else begin
         if (wr_en) begin
            wptr <= wptr + 1'b1;
         end
         if (rd_en) begin
            r_data <= mem[rptr];
            rptr   <= rptr + 1'b1;
         end
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_syn_fifo.sv
// Directed bench for syn_fifo: reset, fill/drain, concurrency, boundary cases, wrap streaming.
module tb_syn_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] w_data;
   logic       w_request;
   logic       r_request;
   logic [7:0] r_data;
   logic       full_status;
   logic       empty_status;

   int n_checks = 0;
   int n_errors = 0;

   syn_fifo #(.WIDTH(8), .DEPTH(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .w_data       (w_data),
      .w_request    (w_request),
      .r_request    (r_request),
      .r_data       (r_data),
      .full_status  (full_status),
      .empty_status (empty_status)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s got 0x%0h want 0x%0h", tag, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic w, input logic r, input logic [7:0] d);
      w_request = w;
      r_request = r;
      w_data    = d;
   endtask

   initial begin
      int wv;
      int rexp;
      int mcnt;
      logic wr_ok;
      logic rd_ok;

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      tick();
      tick();
      rst_n = 1'b1;
      check("rst_empty", 32'(empty_status), 32'd1);
      check("rst_full", 32'(full_status), 32'd0);
      check("rst_rdata", 32'(r_data), 32'h00);

      // Async reset mid-cycle with data stored
      drive(1'b1, 1'b0, 8'hA0); tick();
      drive(1'b1, 1'b0, 8'hA1); tick();
      drive(1'b0, 1'b0, 8'h00);
      check("pre_rst_empty", 32'(empty_status), 32'd0);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_empty", 32'(empty_status), 32'd1);
      check("async_rst_full", 32'(full_status), 32'd0);
      check("async_rst_rdata", 32'(r_data), 32'h00);
      tick();
      rst_n = 1'b1;
      drive(1'b0, 1'b1, 8'h00); tick();
      check("rd_after_rst_rdata", 32'(r_data), 32'h00);
      check("rd_after_rst_empty", 32'(empty_status), 32'd1);

      // Fill
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'(i)); tick();
         check("fill_full", 32'(full_status), (i == 3) ? 32'd1 : 32'd0);
         check("fill_empty", 32'(empty_status), 32'd0);
      end
      drive(1'b1, 1'b0, 8'h04); tick();
      check("overfill_full", 32'(full_status), 32'd1);

      // Drain, fifth read ignored
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'h00); tick();
         check("drain_rdata", 32'(r_data), (i < 4) ? 32'(i) : 32'h03);
         check("drain_empty", 32'(empty_status), (i >= 3) ? 32'd1 : 32'd0);
      end
      check("drain_full", 32'(full_status), 32'd0);

      // Concurrent with two stored
      drive(1'b1, 1'b0, 8'h10); tick();
      drive(1'b1, 1'b0, 8'h11); tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 8'(8'h12 + i)); tick();
         check("conc_rdata", 32'(r_data), 32'(8'h10 + i));
         check("conc_full", 32'(full_status), 32'd0);
         check("conc_empty", 32'(empty_status), 32'd0);
      end
      drive(1'b0, 1'b1, 8'h00); tick();
      check("conc_tail0", 32'(r_data), 32'h13);
      check("conc_tail0_empty", 32'(empty_status), 32'd0);
      tick();
      check("conc_tail1", 32'(r_data), 32'h14);
      check("conc_tail1_empty", 32'(empty_status), 32'd1);

      // Full plus both requests
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b0, 8'(8'h20 + i)); tick();
      end
      check("bfull_pre", 32'(full_status), 32'd1);
      drive(1'b1, 1'b1, 8'h24); tick();
      check("bfull_rdata", 32'(r_data), 32'h20);
      check("bfull_full", 32'(full_status), 32'd0);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 8'h00); tick();
         check("bfull_drain", 32'(r_data), 32'(8'h21 + i));
      end
      check("bfull_dropped_empty", 32'(empty_status), 32'd1);

      // Empty plus both requests
      drive(1'b1, 1'b1, 8'h55); tick();
      check("bempty_rdata", 32'(r_data), 32'h23);
      check("bempty_empty", 32'(empty_status), 32'd0);
      drive(1'b0, 1'b1, 8'h00); tick();
      check("bempty_read", 32'(r_data), 32'h55);
      check("bempty_after", 32'(empty_status), 32'd1);

      // Streaming across several pointer wraps
      wv   = 0;
      rexp = 0;
      mcnt = 0;
      for (int i = 0; i < 100 && rexp < 13; i++) begin
         drive(wv < 13, (i % 3) != 0, 8'(wv));
         wr_ok = w_request && (mcnt < 4);
         rd_ok = r_request && (mcnt > 0);
         tick();
         if (wr_ok) wv++;
         if (rd_ok) begin
            check("wrap_rdata", 32'(r_data), 32'(rexp));
            rexp++;
         end
         mcnt = mcnt + (wr_ok ? 1 : 0) - (rd_ok ? 1 : 0);
         check("wrap_empty", 32'(empty_status), 32'(mcnt == 0));
         check("wrap_full", 32'(full_status), 32'(mcnt == 4));
      end
      check("wrap_done", 32'(rexp), 32'd13);

      // Mid-operation reset with two stale entries
      drive(1'b1, 1'b0, 8'h30); tick();
      drive(1'b1, 1'b0, 8'h31); tick();
      drive(1'b0, 1'b0, 8'h00);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_empty", 32'(empty_status), 32'd1);
      check("mid_rst_rdata", 32'(r_data), 32'h00);
      tick();
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 8'h40); tick();
      drive(1'b0, 1'b1, 8'h00); tick();
      check("post_rst_read", 32'(r_data), 32'h40);
      tick();
      check("post_rst_hold", 32'(r_data), 32'h40);
      check("post_rst_empty", 32'(empty_status), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
